// File: rtl/frac_stepper_if.sv
// Bus bundle for frac_stepper.
//   master: drives the configuration (src_len, dst_len, span, align, interp_en),
//           the control pulses (newfraction, step_reset, step_in) and observes
//           the stepping outputs.
//   slave : the stepper itself; returns ready, step_out, whole, fraction, blank.
interface frac_stepper_if #(
    parameter int BITWIDTH  = 10,
    parameter int FRACWIDTH = 16
);
    logic [BITWIDTH-1:0]  src_len;
    logic [BITWIDTH-1:0]  dst_len;
    logic [BITWIDTH-1:0]  span;
    logic [1:0]           align;
    logic                 interp_en;
    logic                 newfraction;
    logic                 ready;
    logic                 step_reset;
    logic                 step_in;
    logic                 step_out;
    logic [BITWIDTH-1:0]  whole;
    logic [FRACWIDTH-1:0] fraction;
    logic                 blank;

    modport master (
        output src_len, dst_len, span, align, interp_en,
        output newfraction, step_reset, step_in,
        input  ready, step_out, whole, fraction, blank
    );

    modport slave (
        input  src_len, dst_len, span, align, interp_en,
        input  newfraction, step_reset, step_in,
        output ready, step_out, whole, fraction, blank
    );
endinterface

// File: rtl/frac_stepper.sv
// Fixed-point source-position generator for scandoubler upscaling (one per axis).
// A restoring divider computes step = (src_len << FRACWIDTH) / dst_len, one
// quotient bit per cycle. Each accepted destination position (step_in) then
// yields the source index (whole), the interpolation weight (fraction), a
// source-advance strobe (step_out) and blanking, with left/centre/right
// alignment of the active region inside the span.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : frac_stepper_if.slave (configuration, control pulses, outputs)
module frac_stepper #(
    parameter int BITWIDTH  = 10,
    parameter int FRACWIDTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    frac_stepper_if.slave bus
);
    localparam int W  = BITWIDTH + FRACWIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {C_IDLE, C_DIV, C_DONE, C_RUN} ctrl_e;
    typedef enum logic [1:0] {P_LEAD, P_ACTIVE, P_TRAIL} phase_e;

    ctrl_e                state_q, state_d;
    logic                 div_load, div_iter, div_done, running;

    logic [BITWIDTH-1:0]  src_q, src_d, dst_q, dst_d, span_q, span_d;
    logic [1:0]           align_q, align_d;
    logic                 interp_q, interp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BITWIDTH-1:0]  rem_q, rem_d;
    logic [W-1:0]         quo_q, quo_d, step_q, step_d, pos_q, pos_d;
    phase_e               phase_q, phase_d;
    logic [BITWIDTH-1:0]  offset_q, offset_d, k_q, k_d, whole_q, whole_d;
    logic [FRACWIDTH-1:0] frac_q, frac_d;
    logic                 step_out_q, step_out_d, blank_q, blank_d;

    // ---------------- control FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= C_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- control FSM: next state ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (bus.newfraction) begin
            state_d = C_DIV;               // also aborts a running division
        end else begin
            case (state_q)
                C_DIV:   if (cnt_q == '0) state_d = C_DONE;
                C_DONE:  state_d = C_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // ---------------- control FSM: outputs ----------------
    always_comb begin
        div_load = bus.newfraction;
        div_iter = (state_q == C_DIV)  && !bus.newfraction;
        div_done = (state_q == C_DONE) && !bus.newfraction;
        running  = (state_q == C_RUN);
    end

    assign bus.ready = running;

    // ---------------- span start values ----------------
    logic [BITWIDTH-1:0] init_off;
    phase_e              post_lead, init_phase;

    always_comb begin
        init_off = '0;
        if (dst_q < span_q) begin
            case (align_q)
                2'd1:    init_off = (span_q - dst_q) >> 1;
                2'd2:    init_off = span_q - dst_q;
                default: init_off = '0;
            endcase
        end
        // With no active pixels the whole span is blank after the lead-in.
        post_lead  = (dst_q == '0) ? P_TRAIL : P_ACTIVE;
        init_phase = (init_off != '0) ? P_LEAD : post_lead;
    end

    // ---------------- divider and active-position arithmetic ----------------
    logic [BITWIDTH:0]   trial;
    logic [BITWIDTH-1:0] raw_whole, src_max, act_whole;
    logic                sat;

    // Remainder shifted left with the next dividend bit; quo_q holds the
    // unconsumed dividend in its upper bits and the quotient in its lower bits.
    assign trial     = {rem_q, quo_q[W-1]};
    assign raw_whole = pos_q[W-1:FRACWIDTH];
    assign src_max   = src_q - BITWIDTH'(1);
    assign sat       = raw_whole > src_max;
    assign act_whole = sat ? src_max : raw_whole;

    // ---------------- datapath next state ----------------
    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        span_d     = span_q;
        align_d    = align_q;
        interp_d   = interp_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        step_d     = step_q;
        pos_d      = pos_q;
        phase_d    = phase_q;
        offset_d   = offset_q;
        k_d        = k_q;
        whole_d    = whole_q;
        frac_d     = frac_q;
        step_out_d = 1'b0;                 // strobe only on an accepted position
        blank_d    = blank_q;

        if (div_load) begin
            src_d    = bus.src_len;
            dst_d    = bus.dst_len;
            span_d   = bus.span;
            align_d  = bus.align;
            interp_d = bus.interp_en;
            rem_d    = '0;
            quo_d    = {bus.src_len, {FRACWIDTH{1'b0}}};
            cnt_d    = CW'(W - 1);
            blank_d  = 1'b1;
            whole_d  = '0;
            frac_d   = '0;
        end else if (div_iter) begin
            // dst_len == 0 makes every trial succeed: quotient becomes all-ones.
            if (trial >= {1'b0, dst_q}) begin
                rem_d = BITWIDTH'(trial - {1'b0, dst_q});
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial[BITWIDTH-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end else if (div_done || (running && bus.step_reset)) begin
            // step_reset outranks a same-cycle step_in, which is dropped.
            if (div_done) step_d = quo_q;
            phase_d  = init_phase;
            offset_d = init_off;
            k_d      = '0;
            pos_d    = '0;
            whole_d  = '0;
            frac_d   = '0;
            blank_d  = 1'b1;
        end else if (running && bus.step_in) begin
            case (phase_q)
                P_LEAD: begin
                    blank_d  = 1'b1;
                    frac_d   = '0;
                    offset_d = offset_q - BITWIDTH'(1);
                    if (offset_q == BITWIDTH'(1)) phase_d = post_lead;
                end
                P_ACTIVE: begin
                    blank_d    = 1'b0;
                    whole_d    = act_whole;
                    frac_d     = (interp_q && !sat) ? pos_q[FRACWIDTH-1:0] : '0;
                    // whole_q still holds the previous position's index here.
                    step_out_d = (k_q != '0) && (act_whole != whole_q);
                    pos_d      = pos_q + step_q;
                    k_d        = k_q + BITWIDTH'(1);
                    if (k_q == dst_q - BITWIDTH'(1)) phase_d = P_TRAIL;
                end
                default: begin
                    blank_d = 1'b1;
                    frac_d  = '0;
                end
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            span_q     <= '0;
            align_q    <= '0;
            interp_q   <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            step_q     <= '0;
            pos_q      <= '0;
            phase_q    <= P_TRAIL;
            offset_q   <= '0;
            k_q        <= '0;
            whole_q    <= '0;
            frac_q     <= '0;
            step_out_q <= 1'b0;
            blank_q    <= 1'b1;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            span_q     <= span_d;
            align_q    <= align_d;
            interp_q   <= interp_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            phase_q    <= phase_d;
            offset_q   <= offset_d;
            k_q        <= k_d;
            whole_q    <= whole_d;
            frac_q     <= frac_d;
            step_out_q <= step_out_d;
            blank_q    <= blank_d;
        end
    end

    assign bus.step_out = step_out_q;
    assign bus.whole    = whole_q;
    assign bus.fraction = frac_q;
    assign bus.blank    = blank_q;
endmodule

// File: tb/tb_frac_stepper.sv
// Scoreboard bench for frac_stepper: the stimulus process pushes the expected
// output of each accepted position (from an arithmetic reference model) and a
// monitor pops and compares on every position the DUT accepts.
module tb_frac_stepper;
    localparam int BW = 10;
    localparam int FW = 16;
    localparam int W  = BW + FW;

    typedef struct packed {
        logic [BW-1:0] whole;
        logic [FW-1:0] frac;
        logic          step_out;
        logic          blank;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    frac_stepper_if #(.BITWIDTH(BW), .FRACWIDTH(FW)) bus ();
    frac_stepper #(.BITWIDTH(BW), .FRACWIDTH(FW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    bit   mon_en   = 1'b0;
    bit   mon_pend = 1'b0;
    exp_t mon_e;

    // current model configuration and position count since span start
    int cs, cd, cspan, calign;
    bit cinterp;
    int p;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic longint step_val();
        return (longint'(cs) << FW) / longint'(cd);
    endfunction

    function automatic int whole_at(int k);
        longint w;
        w = (longint'(k) * step_val()) >> FW;
        if (w > cs - 1) w = cs - 1;
        return int'(w);
    endfunction

    function automatic exp_t model(int pp);
        exp_t   e;
        int     off, k;
        longint pos;
        e.whole = '0; e.frac = '0; e.step_out = 1'b0; e.blank = 1'b1;
        if (cd >= cspan)      off = 0;
        else if (calign == 1) off = (cspan - cd) / 2;
        else if (calign == 2) off = cspan - cd;
        else                  off = 0;
        if (cd == 0 || pp < off) return e;
        k = pp - off;
        if (k >= cd) begin
            e.whole = BW'(whole_at(cd - 1));
            return e;
        end
        pos     = longint'(k) * step_val();
        e.whole = BW'(whole_at(k));
        e.blank = 1'b0;
        if (cinterp && ((pos >> FW) <= cs - 1)) e.frac = FW'(pos % (64'd1 << FW));
        e.step_out = (k > 0) && (whole_at(k) != whole_at(k - 1));
        return e;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mon_pend) begin
                    if (sb_q.size() == 0) begin
                        fail_event("unexpected_position");
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("whole",    bus.whole,    mon_e.whole);
                        check("fraction", bus.fraction, mon_e.frac);
                        check("step_out", bus.step_out, mon_e.step_out);
                        check("blank",    bus.blank,    mon_e.blank);
                    end
                end else begin
                    check("idle_step_out", bus.step_out, 1'b0);
                end
                mon_pend = bus.step_in && bus.ready && !bus.step_reset &&
                           !bus.newfraction && reset_n;
            end else begin
                mon_pend = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers (all start at posedge+2) ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_newfraction();
        bus.newfraction = 1'b1;
        tick();
        bus.newfraction = 1'b0;
    endtask

    task automatic wait_ready();
        int lat = 0;
        forever begin
            @(negedge clk);
            if (bus.ready === 1'b1) break;
            @(posedge clk);
            #2;
            lat++;
            if (lat > 80) break;
        end
        if (lat > 80) fail_event("ready_timeout");
        else check("ready_latency", lat, W + 1);
        @(posedge clk);
        #2;
    endtask

    task automatic configure(int s, int d, int sp, int al, bit ip);
        bus.src_len   = BW'(s);
        bus.dst_len   = BW'(d);
        bus.span      = BW'(sp);
        bus.align     = 2'(al);
        bus.interp_en = ip;
        cs = s; cd = d; cspan = sp; calign = al; cinterp = ip;
        p = 0;
        pulse_newfraction();
        wait_ready();
    endtask

    task automatic do_steps(int n, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            bus.step_in = 1'b1;
            sb_q.push_back(model(p));
            p++;
            tick();
            bus.step_in = 1'b0;
        end
    endtask

    task automatic span_restart(bit with_step);
        bus.step_reset = 1'b1;
        bus.step_in    = with_step;
        tick();
        bus.step_reset = 1'b0;
        bus.step_in    = 1'b0;
        p = 0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int d, s, sp, n;
        reset_n         = 1'b0;
        bus.src_len     = '0;
        bus.dst_len     = '0;
        bus.span        = '0;
        bus.align       = '0;
        bus.interp_en   = 1'b0;
        bus.newfraction = 1'b0;
        bus.step_reset  = 1'b0;
        bus.step_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    bus.ready,    1'b0);
        check("rst_step_out", bus.step_out, 1'b0);
        check("rst_whole",    bus.whole,    '0);
        check("rst_fraction", bus.fraction, '0);
        check("rst_blank",    bus.blank,    1'b1);
        tick();
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick();

        // T1: latency and step 0x6DB6 seen through fraction of position 1
        configure(3, 7, 7, 0, 1);
        do_steps(9, 0);
        // T2: left, interpolated
        configure(4, 8, 8, 0, 1);
        do_steps(10, 0);
        // T3: centre and right alignment
        configure(4, 8, 11, 1, 1);
        do_steps(13, 1);
        configure(4, 8, 11, 2, 1);
        do_steps(13, 0);
        // T4: nearest neighbour
        configure(4, 8, 8, 0, 0);
        do_steps(10, 0);

        // T6: step_reset with step_in mid-span
        configure(4, 8, 8, 0, 1);
        do_steps(4, 0);
        span_restart(1'b1);
        @(negedge clk);
        check("rst_span_whole",    bus.whole,    '0);
        check("rst_span_step_out", bus.step_out, 1'b0);
        check("rst_span_blank",    bus.blank,    1'b1);
        @(posedge clk);
        #2;
        do_steps(10, 1);
        // async reset mid-span
        span_restart(1'b0);
        do_steps(5, 0);
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready",    bus.ready,    1'b0);
        check("mid_rst_whole",    bus.whole,    '0);
        check("mid_rst_fraction", bus.fraction, '0);
        check("mid_rst_blank",    bus.blank,    1'b1);
        check("mid_rst_step_out", bus.step_out, 1'b0);
        sb_q.delete();
        tick();
        reset_n = 1'b1;
        tick();

        // T5: abort mid-divide, restart with dst_len = 0
        bus.src_len = BW'(4); bus.dst_len = BW'(8); bus.span = BW'(10);
        bus.align = 2'd1; bus.interp_en = 1'b1;
        pulse_newfraction();
        for (int i = 0; i < 10; i++) begin
            bus.step_in = 1'b1;
            @(negedge clk);
            check("busy_ready", bus.ready, 1'b0);
            check("busy_blank", bus.blank, 1'b1);
            @(posedge clk);
            #2;
        end
        bus.step_in = 1'b0;
        configure(4, 0, 10, 1, 1);
        do_steps(12, 1);

        // randomized configurations
        for (int t = 0; t < 20; t++) begin
            d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
            s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60))
                                             : int'($urandom_range(1, (d > 0) ? d : 1));
            sp = int'($urandom_range((d > 5) ? d - 5 : 0, d + 12));
            configure(s, d, sp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            n = ((sp > d) ? sp : d) + 3;
            if ($urandom_range(0, 2) == 0) begin
                do_steps(int'($urandom_range(1, n)), 1);
                span_restart(1'($urandom_range(0, 1)));
            end
            do_steps(n, 1);
        end

        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
